// File: rtl/m_d_areg_queue.sv
// Multi-entry memory-to-data-cache access register: a DEPTH-deep circular
// buffer of flit bundles, presenting the oldest entry to the cache until it is popped.
module m_d_areg_queue #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] m_flits_d,
  input  logic              v_m_flits_d,
  input  logic              dc_done_access,
  input  logic              ovf_clr,
  output logic [FLIT_W-1:0] m_d_areg_flits,
  output logic              v_m_d_areg_flits,
  output logic              m_d_areg_state,
  output logic [PTR_W:0]    m_d_areg_count,
  output logic              m_d_areg_ovf
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  // Handshake: v_m_flits_d is a one-cycle push strobe with no ready; the sender
  // must watch m_d_areg_state and any push while full without a pop is dropped
  // and flagged. dc_done_access pops the head; it is ignored when empty.

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              ovf;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic push_drop;

  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    push_ok   = v_m_flits_d & (~full | dc_done_access);
    pop_ok    = dc_done_access & ~empty;
    push_drop = v_m_flits_d & ~push_ok;
  end

  // When full, a paired push and pop hit the same slot; the push write is
  // placed last so the new data survives over the free-zeroing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop_ok) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        mem[wr_ptr] <= m_flits_d;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push_drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    m_d_areg_flits   = empty ? '0 : mem[rd_ptr];
    v_m_d_areg_flits = ~empty;
    m_d_areg_state   = full;
    m_d_areg_count   = count;
    m_d_areg_ovf     = ovf;
  end

endmodule
